// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC and loads the IF/ID register, with stall,
// redirect/flush, end-of-program and bad-target fault handling.
//
// state    | meaning
// ST_RUN   | fetching sequentially, IF/ID gets real instructions
// ST_END   | ran off the end of memory; PC parked, NOPs injected until redirect
// ST_FAULT | bad redirect target seen; frozen until reset
module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int          MEM_BYTES = 256,
   parameter logic [31:0] NOP       = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [63:0] Branch_Target,
   input  logic [31:0] Instruction,
   output logic [63:0] Inst_Address,
   output logic [63:0] IF_ID_PC,
   output logic [31:0] IF_ID_Instruction,
   output logic        IF_ID_Valid,
   output logic        Fetch_Fault,
   output logic [31:0] Fetch_Count,
   output logic [31:0] Bubble_Count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_END   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [64:0] LAST_WORD = 65'(MEM_BYTES - 4);

   state_t      state_q;
   logic [63:0] pc_q;
   logic [63:0] ifid_pc_q;
   logic [31:0] ifid_instr_q;
   logic        ifid_valid_q;
   logic        fault_q;
   logic [31:0] fetch_q;
   logic [31:0] bubble_q;
   logic [64:0] pc_plus4;

   // 65-bit so a wrap past 2^64 lands above LAST_WORD and reads as illegal
   function automatic logic is_legal(input logic [64:0] addr);
      return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
   endfunction

   assign pc_plus4 = {1'b0, pc_q} + 65'd4;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
         fault_q      <= 1'b0;
         fetch_q      <= 32'd0;
         bubble_q     <= 32'd0;
      end else if (state_q == ST_FAULT) begin
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
         bubble_q     <= sat_inc(bubble_q);
      end else if (Branch_Taken) begin
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
         bubble_q     <= sat_inc(bubble_q);
         if (is_legal({1'b0, Branch_Target})) begin
            pc_q    <= Branch_Target;
            state_q <= ST_RUN;
         end else begin
            fault_q <= 1'b1;
            state_q <= ST_FAULT;
         end
      end else if (!Stall) begin
         if (state_q == ST_RUN) begin
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= Instruction;
            ifid_valid_q <= 1'b1;
            fetch_q      <= sat_inc(fetch_q);
            if (is_legal(pc_plus4)) begin
               pc_q <= pc_plus4[63:0];
            end else begin
               state_q <= ST_END;
            end
         end else begin
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            bubble_q     <= sat_inc(bubble_q);
         end
      end
   end

   assign Inst_Address      = pc_q;
   assign IF_ID_PC          = ifid_pc_q;
   assign IF_ID_Instruction = ifid_instr_q;
   assign IF_ID_Valid       = ifid_valid_q;
   assign Fetch_Fault       = fault_q;
   assign Fetch_Count       = fetch_q;
   assign Bubble_Count      = bubble_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a behavioural model predicts each
// edge, expectations are queued at drive time and popped after the edge.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic        Stall;
   logic        Branch_Taken;
   logic [63:0] Branch_Target;
   logic [31:0] Instruction;
   logic [63:0] Inst_Address;
   logic [63:0] IF_ID_PC;
   logic [31:0] IF_ID_Instruction;
   logic        IF_ID_Valid;
   logic        Fetch_Fault;
   logic [31:0] Fetch_Count;
   logic [31:0] Bubble_Count;

   instruction_fetch_unit #(
      .RESET_PC (64'd0),
      .MEM_BYTES(256),
      .NOP      (NOP)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .Stall            (Stall),
      .Branch_Taken     (Branch_Taken),
      .Branch_Target    (Branch_Target),
      .Instruction      (Instruction),
      .Inst_Address     (Inst_Address),
      .IF_ID_PC         (IF_ID_PC),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_Valid      (IF_ID_Valid),
      .Fetch_Fault      (Fetch_Fault),
      .Fetch_Count      (Fetch_Count),
      .Bubble_Count     (Bubble_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // addi x5,x0,<pc>: every word differs so a wrong capture is visible
   function automatic logic [31:0] imem(input logic [63:0] a);
      return 32'h00000293 | {a[11:0], 20'd0};
   endfunction

   assign Instruction = imem(Inst_Address);

   typedef struct {
      logic [63:0] pc;
      logic [63:0] ifpc;
      logic [31:0] ifinstr;
      logic        valid;
      logic        fault;
      logic [31:0] fc;
      logic [31:0] bc;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // model state: 0 run, 1 end, 2 fault
   int          m_state;
   logic [63:0] m_pc;
   logic [63:0] m_ifpc;
   logic [31:0] m_ifinstr;
   logic        m_valid;
   logic        m_fault;
   logic [31:0] m_fc;
   logic [31:0] m_bc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [64:0] a);
      return (a[1:0] == 2'b00) && (a <= 65'd252);
   endfunction

   function automatic logic [31:0] bump(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   task automatic model_bubble();
      m_ifpc    = 64'd0;
      m_ifinstr = NOP;
      m_valid   = 1'b0;
      m_bc      = bump(m_bc);
   endtask

   task automatic model_edge(input logic rst_n, input logic st, input logic br,
                             input logic [63:0] tgt);
      logic [64:0] nxt;
      if (!rst_n) begin
         m_state = 0; m_pc = 64'd0; m_ifpc = 64'd0; m_ifinstr = NOP;
         m_valid = 1'b0; m_fault = 1'b0; m_fc = 32'd0; m_bc = 32'd0;
      end else if (m_state == 2) begin
         model_bubble();
      end else if (br) begin
         model_bubble();
         if (legal({1'b0, tgt})) begin
            m_pc = tgt;
            m_state = 0;
         end else begin
            m_fault = 1'b1;
            m_state = 2;
         end
      end else if (st) begin
         // hold everything
      end else if (m_state == 0) begin
         m_ifpc    = m_pc;
         m_ifinstr = imem(m_pc);
         m_valid   = 1'b1;
         m_fc      = bump(m_fc);
         nxt       = {1'b0, m_pc} + 65'd4;
         if (legal(nxt)) m_pc = nxt[63:0];
         else            m_state = 1;
      end else begin
         model_bubble();
      end
   endtask

   task automatic step(input logic rst_n, input logic st, input logic br,
                       input logic [63:0] tgt);
      exp_t e;
      @(negedge clk);
      reset = rst_n; Stall = st; Branch_Taken = br; Branch_Target = tgt;
      model_edge(rst_n, st, br, tgt);
      e.pc = m_pc; e.ifpc = m_ifpc; e.ifinstr = m_ifinstr; e.valid = m_valid;
      e.fault = m_fault; e.fc = m_fc; e.bc = m_bc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("inst_address", Inst_Address, e.pc);
         check("if_id_pc", IF_ID_PC, e.ifpc);
         check("if_id_instr", {32'd0, IF_ID_Instruction}, {32'd0, e.ifinstr});
         check("if_id_valid", {63'd0, IF_ID_Valid}, {63'd0, e.valid});
         check("fetch_fault", {63'd0, Fetch_Fault}, {63'd0, e.fault});
         check("fetch_count", {32'd0, Fetch_Count}, {32'd0, e.fc});
         check("bubble_count", {32'd0, Bubble_Count}, {32'd0, e.bc});
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 64'd0;
      m_state = 0; m_pc = 64'd0; m_ifpc = 64'd0; m_ifinstr = NOP;
      m_valid = 1'b0; m_fault = 1'b0; m_fc = 32'd0; m_bc = 32'd0;

      // reset wins even with branch and stall asserted
      step(1'b0, 1'b1, 1'b1, 64'h1C);
      step(1'b0, 1'b0, 1'b0, 64'd0);

      // free run 0,4,8,12 then a 2-cycle stall at PC=12
      run(3);
      step(1'b1, 1'b1, 1'b0, 64'd0);
      step(1'b1, 1'b1, 1'b0, 64'd0);
      run(1);

      // advance to PC=44, redirect to 0x1C with a simultaneous stall
      for (int i = 0; i < 100 && m_pc != 64'd44; i++) run(1);
      check("reached_pc44", Inst_Address, 64'd44);
      step(1'b1, 1'b1, 1'b1, 64'h1C);
      run(2);

      // run off the end at 252, stall and idle in END, then redirect to 0
      for (int i = 0; i < 100 && m_state == 0; i++) run(1);
      check("end_pc_parked", Inst_Address, 64'd252);
      run(2);
      step(1'b1, 1'b1, 1'b0, 64'd0);
      step(1'b1, 1'b0, 1'b1, 64'd0);
      run(3);

      // redirect to last legal word: captured, then straight to END
      step(1'b1, 1'b0, 1'b1, 64'hFC);
      run(2);

      // misaligned target faults; later branches are ignored
      step(1'b1, 1'b0, 1'b1, 64'h1E);
      step(1'b1, 1'b0, 1'b1, 64'h10);
      step(1'b1, 1'b1, 1'b0, 64'd0);

      // bubble counter saturation while in FAULT
      @(negedge clk);
      dut.bubble_q = 32'hFFFF_FFFE;
      m_bc = 32'hFFFF_FFFE;
      run(3);
      check("bubble_saturated", {32'd0, Bubble_Count}, 64'hFFFF_FFFF);

      // reset clears, then out-of-range and wrap-range targets
      step(1'b0, 1'b0, 1'b1, 64'h10);
      run(2);
      step(1'b1, 1'b0, 1'b1, 64'h100);
      run(1);
      step(1'b0, 1'b0, 1'b0, 64'd0);
      run(1);
      step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      run(1);
      step(1'b0, 1'b0, 1'b0, 64'd0);
      run(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
